// File: rtl/mod_dds_seq.sv
`default_nettype none
// ============================================================================
// Module   : mod_dds_seq
// Purpose  : Table-driven sequencer for one mod_dds modulated DDS channel.
//            Firmware loads up to NE register profiles into a local
//            flip-flop table and issues start. Each profile is played as:
//            LOAD (drive register set, pulse WE_REG), SETTLE cycles of
//            register settling, RUN (trigger high for DUR cycles), GAP
//            (trigger low). An optional loop wraps back to entry 0.
// Ports    : clk, rstn             clock, asynchronous active-low reset
//            cfg_we/addr/data      table write port (always accepted)
//            cfg_len, cfg_loop     play length and loop flag, sampled at start
//            start, stop           single-cycle start / abort requests
//            WAIT_REG..POFF_REG    mod_dds register set (registered)
//            WE_REG, trigger       mod_dds write strobe and trigger
//            busy, idx, done       status: active, current entry, completion
// Entry    : LSB first: WAIT[BT], FMOD_C0..C5[18], FMOD_G[18], AMOD_C0[16],
//            AMOD_C1[16], POFF[18], DUR[BT]
// Revision : 1.0 - initial release
// ============================================================================
module mod_dds_seq #(
    parameter int BT     = 16,
    parameter int NE     = 8,
    parameter int AW     = 3,
    parameter int SETTLE = 2,
    parameter int GAP    = 2
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 cfg_we,
    input  logic [AW-1:0]        cfg_addr,
    input  logic [2*BT+176-1:0]  cfg_data,
    input  logic [AW:0]          cfg_len,
    input  logic                 cfg_loop,
    input  logic                 start,
    input  logic                 stop,
    output logic [BT-1:0]        WAIT_REG,
    output logic [17:0]          FMOD_C0_REG,
    output logic [17:0]          FMOD_C1_REG,
    output logic [17:0]          FMOD_C2_REG,
    output logic [17:0]          FMOD_C3_REG,
    output logic [17:0]          FMOD_C4_REG,
    output logic [17:0]          FMOD_C5_REG,
    output logic [17:0]          FMOD_G_REG,
    output logic [15:0]          AMOD_C0_REG,
    output logic [15:0]          AMOD_C1_REG,
    output logic [17:0]          POFF_REG,
    output logic                 WE_REG,
    output logic                 trigger,
    output logic                 busy,
    output logic [AW-1:0]        idx,
    output logic                 done
);

    localparam int EW      = 2*BT + 176;
    localparam int OFF_FC0 = BT;
    localparam int OFF_FG  = BT + 108;
    localparam int OFF_AC0 = BT + 126;
    localparam int OFF_AC1 = BT + 142;
    localparam int OFF_PO  = BT + 158;
    localparam int OFF_DUR = BT + 176;

    // Counter reload values; SETTLE=0 skips the SETTLE state entirely.
    localparam logic [BT-1:0] c_settle_m1 = BT'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam logic [BT-1:0] c_gap_m1    = BT'(GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_RUN    = 3'd3,
        S_GAP    = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t          state_q;
    logic [EW-1:0]   tbl_q [NE];
    logic [AW:0]     len_q;
    logic            loop_q;
    logic [BT-1:0]   dur_q;
    logic [BT-1:0]   cnt_q;

    logic [AW-1:0]   idx_d;
    logic            last_d;
    logic            go_load_d;
    logic [EW-1:0]   ent_d;
    logic [BT-1:0]   ent_dur_d;

    // Profile table: plain flip-flops, no reset, writable at any time.
    always_ff @(posedge clk) begin
        if (cfg_we) begin
            tbl_q[cfg_addr] <= cfg_data;
        end
    end

    // Entry selection for the next LOAD: idx+1 mid-sequence, 0 on start/wrap.
    always_comb begin
        last_d    = (({1'b0, idx} + {{AW{1'b0}}, 1'b1}) >= len_q);
        idx_d     = (state_q == S_GAP && !last_d) ? idx + 1'b1 : '0;
        go_load_d = !stop &&
                    ((state_q == S_IDLE && start && cfg_len != '0) ||
                     (state_q == S_GAP && cnt_q == '0 && (!last_d || loop_q)));
        ent_d     = tbl_q[idx_d];
        ent_dur_d = ent_d[OFF_DUR +: BT];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            loop_q      <= 1'b0;
            dur_q       <= '0;
            cnt_q       <= '0;
            WAIT_REG    <= '0;
            FMOD_C0_REG <= '0;
            FMOD_C1_REG <= '0;
            FMOD_C2_REG <= '0;
            FMOD_C3_REG <= '0;
            FMOD_C4_REG <= '0;
            FMOD_C5_REG <= '0;
            FMOD_G_REG  <= '0;
            AMOD_C0_REG <= '0;
            AMOD_C1_REG <= '0;
            POFF_REG    <= '0;
            WE_REG      <= 1'b0;
            trigger     <= 1'b0;
            busy        <= 1'b0;
            idx         <= '0;
            done        <= 1'b0;
        end else begin
            WE_REG <= 1'b0;
            done   <= 1'b0;

            if (stop && state_q != S_IDLE) begin
                // Abort: no done pulse, trigger drops on this edge.
                state_q <= S_IDLE;
                trigger <= 1'b0;
                busy    <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start && !stop) begin
                            len_q  <= cfg_len;
                            loop_q <= cfg_loop;
                            busy   <= 1'b1;
                            if (cfg_len == '0) begin
                                state_q <= S_FIN;
                                done    <= 1'b1;
                            end else begin
                                state_q <= S_LOAD;
                            end
                        end
                    end
                    S_LOAD: begin
                        if (SETTLE == 0) begin
                            state_q <= S_RUN;
                            trigger <= 1'b1;
                            cnt_q   <= dur_q - 1'b1;
                        end else begin
                            state_q <= S_SETTLE;
                            cnt_q   <= c_settle_m1;
                        end
                    end
                    S_SETTLE: begin
                        if (cnt_q == '0) begin
                            state_q <= S_RUN;
                            trigger <= 1'b1;
                            cnt_q   <= dur_q - 1'b1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (cnt_q == '0) begin
                            state_q <= S_GAP;
                            trigger <= 1'b0;
                            cnt_q   <= c_gap_m1;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_GAP: begin
                        if (cnt_q == '0) begin
                            if (go_load_d) begin
                                state_q <= S_LOAD;
                            end else begin
                                state_q <= S_FIN;
                                done    <= 1'b1;
                            end
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_FIN: begin
                        state_q <= S_IDLE;
                        busy    <= 1'b0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                        trigger <= 1'b0;
                        busy    <= 1'b0;
                    end
                endcase

                // Register set is captured on entry to LOAD so that later
                // table writes cannot disturb the profile being played.
                if (go_load_d) begin
                    idx         <= idx_d;
                    WE_REG      <= 1'b1;
                    WAIT_REG    <= ent_d[0 +: BT];
                    FMOD_C0_REG <= ent_d[OFF_FC0      +: 18];
                    FMOD_C1_REG <= ent_d[OFF_FC0 + 18 +: 18];
                    FMOD_C2_REG <= ent_d[OFF_FC0 + 36 +: 18];
                    FMOD_C3_REG <= ent_d[OFF_FC0 + 54 +: 18];
                    FMOD_C4_REG <= ent_d[OFF_FC0 + 72 +: 18];
                    FMOD_C5_REG <= ent_d[OFF_FC0 + 90 +: 18];
                    FMOD_G_REG  <= ent_d[OFF_FG  +: 18];
                    AMOD_C0_REG <= ent_d[OFF_AC0 +: 16];
                    AMOD_C1_REG <= ent_d[OFF_AC1 +: 16];
                    POFF_REG    <= ent_d[OFF_PO  +: 18];
                    // A zero duration still produces a one-cycle trigger.
                    dur_q       <= (ent_dur_d == '0) ? {{(BT-1){1'b0}}, 1'b1} : ent_dur_d;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mod_dds_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mod_dds_seq
// Purpose  : Directed self-checking bench for mod_dds_seq with default
//            parameters (SETTLE=2, GAP=2). Cycle n is the cycle after
//            clock edge n-1; start is sampled at edge 0.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mod_dds_seq;

    localparam int BT = 16;
    localparam int NE = 8;
    localparam int AW = 3;
    localparam int EW = 2*BT + 176;

    logic              clk      = 1'b0;
    logic              rstn     = 1'b0;
    logic              cfg_we   = 1'b0;
    logic [AW-1:0]     cfg_addr = '0;
    logic [EW-1:0]     cfg_data = '0;
    logic [AW:0]       cfg_len  = '0;
    logic              cfg_loop = 1'b0;
    logic              start    = 1'b0;
    logic              stop     = 1'b0;

    logic [BT-1:0]     WAIT_REG;
    logic [17:0]       FMOD_C0_REG, FMOD_C1_REG, FMOD_C2_REG, FMOD_C3_REG;
    logic [17:0]       FMOD_C4_REG, FMOD_C5_REG, FMOD_G_REG, POFF_REG;
    logic [15:0]       AMOD_C0_REG, AMOD_C1_REG;
    logic              WE_REG, trigger, busy, done;
    logic [AW-1:0]     idx;

    int n_chk  = 0;
    int n_fail = 0;

    // Per-cycle trace of one sequence, bit/element n = cycle n.
    logic [63:0]   tr_v, we_v, dn_v, by_v;
    logic [AW-1:0] ix_a [64];
    logic [BT-1:0] wt_a [64];

    mod_dds_seq #(
        .BT(BT), .NE(NE), .AW(AW), .SETTLE(2), .GAP(2)
    ) u_dut (
        .clk         (clk),
        .rstn        (rstn),
        .cfg_we      (cfg_we),
        .cfg_addr    (cfg_addr),
        .cfg_data    (cfg_data),
        .cfg_len     (cfg_len),
        .cfg_loop    (cfg_loop),
        .start       (start),
        .stop        (stop),
        .WAIT_REG    (WAIT_REG),
        .FMOD_C0_REG (FMOD_C0_REG),
        .FMOD_C1_REG (FMOD_C1_REG),
        .FMOD_C2_REG (FMOD_C2_REG),
        .FMOD_C3_REG (FMOD_C3_REG),
        .FMOD_C4_REG (FMOD_C4_REG),
        .FMOD_C5_REG (FMOD_C5_REG),
        .FMOD_G_REG  (FMOD_G_REG),
        .AMOD_C0_REG (AMOD_C0_REG),
        .AMOD_C1_REG (AMOD_C1_REG),
        .POFF_REG    (POFF_REG),
        .WE_REG      (WE_REG),
        .trigger     (trigger),
        .busy        (busy),
        .idx         (idx),
        .done        (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [EW-1:0] mk_entry(
        input logic [BT-1:0] wt,
        input logic [17:0] c0, input logic [17:0] c1, input logic [17:0] c2,
        input logic [17:0] c3, input logic [17:0] c4, input logic [17:0] c5,
        input logic [17:0] g,  input logic [15:0] a0, input logic [15:0] a1,
        input logic [17:0] po, input logic [BT-1:0] dur);
        return {dur, po, a1, a0, g, c5, c4, c3, c2, c1, c0, wt};
    endfunction

    task automatic write_entry(input int a, input logic [EW-1:0] d);
        cfg_addr = AW'(a);
        cfg_data = d;
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
    endtask

    // Start at edge 0 and trace cycles 1..ncyc; optional extra start / stop
    // pulses are driven during the given cycle (0 = none).
    task automatic run_seq(input int ncyc, input int restart_at, input int stop_at);
        tr_v = '0; we_v = '0; dn_v = '0; by_v = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
            tr_v[c] = trigger;
            we_v[c] = WE_REG;
            dn_v[c] = done;
            by_v[c] = busy;
            ix_a[c] = idx;
            wt_a[c] = WAIT_REG;
            start   = (c == restart_at);
            stop    = (c == stop_at);
            tick();
        end
        start = 1'b0;
        stop  = 1'b0;
    endtask

    initial begin
        // ---------------- reset ----------------
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_trigger", trigger, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_we", WE_REG, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_wait", WAIT_REG, 0);
        check_eq("rst_fc1", FMOD_C1_REG, 0);
        rstn = 1'b1;
        tick();

        // ---------------- single entry, defaults ----------------
        write_entry(0, mk_entry(16'h0042, 18'd0, 18'd260779, 18'd102400, 18'd193877,
                                18'd0, 18'd0, 18'd32440, 16'd0, 16'd49480, 18'd0, 16'd10));
        cfg_len  = 4'd1;
        cfg_loop = 1'b0;
        run_seq(20, 0, 0);
        check_eq("t1_we_cycle1", we_v[1], 1);
        check_eq("t1_we_count", $countones(we_v), 1);
        check_eq("t1_wait_c1", wt_a[1], 16'h0042);
        check_eq("t1_trigger_mask", tr_v, 64'h0000_0000_0000_3FF0);
        check_eq("t1_done_mask", dn_v, 64'h0000_0000_0001_0000);
        check_eq("t1_busy_c16", by_v[16], 1);
        check_eq("t1_busy_c17", by_v[17], 0);
        check_eq("t1_no_overlap", tr_v & we_v, 0);
        check_eq("t1_fc1", FMOD_C1_REG, 18'd260779);
        check_eq("t1_fc2", FMOD_C2_REG, 18'd102400);
        check_eq("t1_fc3", FMOD_C3_REG, 18'd193877);
        check_eq("t1_fg", FMOD_G_REG, 18'd32440);
        check_eq("t1_ac1", AMOD_C1_REG, 16'd49480);
        check_eq("t1_fc0", FMOD_C0_REG, 0);

        // ---------------- three entries, DUR 5/1/0, start while busy ----------------
        write_entry(0, mk_entry(16'hA000, 18'd10, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0,
                                18'd0, 16'd0, 16'd0, 18'd0, 16'd5));
        write_entry(1, mk_entry(16'hA001, 18'd11, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0,
                                18'd0, 16'd0, 16'd0, 18'd0, 16'd1));
        write_entry(2, mk_entry(16'hA002, 18'd12, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0,
                                18'd0, 16'd0, 16'd0, 18'd777, 16'd0));
        cfg_len = 4'd3;
        run_seq(26, 12, 0);
        check_eq("t2_we_mask", we_v, 64'h0000_0000_0002_0802);
        check_eq("t2_trigger_mask", tr_v, 64'h0000_0000_0010_41F0);
        check_eq("t2_done_mask", dn_v, 64'h0000_0000_0080_0000);
        check_eq("t2_idx_c10", ix_a[10], 0);
        check_eq("t2_idx_c12", ix_a[12], 1);
        check_eq("t2_idx_c18", ix_a[18], 2);
        check_eq("t2_wait_c11", wt_a[11], 16'hA001);
        check_eq("t2_wait_c17", wt_a[17], 16'hA002);
        check_eq("t2_poff_hold", POFF_REG, 18'd777);
        check_eq("t2_busy_c24", by_v[24], 0);
        check_eq("t2_no_overlap", tr_v & we_v, 0);

        // ---------------- loop with stop ----------------
        cfg_len  = 4'd2;
        cfg_loop = 1'b1;
        run_seq(30, 0, 22);
        cfg_loop = 1'b0;
        check_eq("t3_we_mask", we_v, 64'h0000_0000_0002_0802);
        check_eq("t3_idx_c11", ix_a[11], 1);
        check_eq("t3_idx_c17", ix_a[17], 0);
        check_eq("t3_trig_c22", tr_v[22], 1);
        check_eq("t3_trig_c23", tr_v[23], 0);
        check_eq("t3_busy_after", by_v[30:23], 0);
        check_eq("t3_no_done", dn_v, 0);

        // ---------------- table rewrite during RUN, then reset ----------------
        write_entry(0, mk_entry(16'h1111, 18'd1000, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0,
                                18'd0, 16'd0, 16'd0, 18'd0, 16'd5));
        cfg_len  = 4'd1;
        cfg_loop = 1'b1;
        start = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        check_eq("t4_we_c1", WE_REG, 1);
        repeat (4) tick();                        // cycle 5
        check_eq("t4_trig_c5", trigger, 1);
        cfg_addr = '0;
        cfg_data = mk_entry(16'h2222, 18'd2000, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0,
                            18'd0, 16'd0, 16'd0, 18'd0, 16'd5);
        cfg_we   = 1'b1;
        tick();                                   // cycle 6
        cfg_we   = 1'b0;
        check_eq("t4_wait_hold", WAIT_REG, 16'h1111);
        check_eq("t4_fc0_hold", FMOD_C0_REG, 18'd1000);
        repeat (5) tick();                        // cycle 11
        check_eq("t4_we_c11", WE_REG, 1);
        check_eq("t4_wait_new", WAIT_REG, 16'h2222);
        check_eq("t4_fc0_new", FMOD_C0_REG, 18'd2000);
        repeat (4) tick();                        // cycle 15, RUN
        check_eq("t4_trig_c15", trigger, 1);
        #2;
        rstn = 1'b0;
        #1;
        check_eq("t4_rst_trigger", trigger, 0);
        check_eq("t4_rst_busy", busy, 0);
        check_eq("t4_rst_wait", WAIT_REG, 0);
        check_eq("t4_rst_fc0", FMOD_C0_REG, 0);
        @(posedge clk);
        #1;
        rstn     = 1'b1;
        cfg_loop = 1'b0;
        tick();
        check_eq("t4_idle_busy", busy, 0);

        // ---------------- len = 0 ----------------
        cfg_len = '0;
        start = 1'b1;
        tick();                                   // cycle 1
        start = 1'b0;
        check_eq("t5_done_c1", done, 1);
        check_eq("t5_busy_c1", busy, 1);
        check_eq("t5_we_c1", WE_REG, 0);
        tick();                                   // cycle 2
        check_eq("t5_done_c2", done, 0);
        check_eq("t5_busy_c2", busy, 0);
        check_eq("t5_we_c2", WE_REG, 0);

        // ---------------- start + stop together in IDLE ----------------
        cfg_len = 4'd1;
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check_eq("t6_busy_c1", busy, 0);
        check_eq("t6_we_c1", WE_REG, 0);
        tick();
        check_eq("t6_busy_c2", busy, 0);
        check_eq("t6_we_c2", WE_REG, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
